// File: rtl/mips_multicycle_core.sv
// Multi-cycle MIPS-subset core: one shared ALU, one unified req/ready memory port, FSM-sequenced.
// Optional feature macro MIPS_MC_ILLEGAL_TRAP_EN: undefined opcodes/functs halt the core instead of acting as NOPs.
module mips_multicycle_core #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          ADDR_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] pc,
  output logic              retire,
  output logic              halted
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_HALT  = 6'h3F;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_t;

  state_t state_q, state_d;

  logic [ADDR_W-1:0] pc_q;
  logic [31:0]       ir_q;
  logic [31:0]       a_q, b_q, alu_q, mdr_q, tgt_q;
  logic [31:0]       rf [32];

  logic [5:0]         opc, fn;
  logic [4:0]         rs, rt, rd;
  logic signed [31:0] imm_sx;

  assign opc    = ir_q[31:26];
  assign rs     = ir_q[25:21];
  assign rt     = ir_q[20:16];
  assign rd     = ir_q[15:11];
  assign fn     = ir_q[5:0];
  assign imm_sx = {{16{ir_q[15]}}, ir_q[15:0]};

  logic is_r, r_ok, is_addi, is_lw, is_sw, is_beq, is_bne, is_j, is_halt, illegal;

  assign is_r    = (opc == OP_RTYPE);
  assign r_ok    = (fn == FN_ADD) || (fn == FN_SUB) || (fn == FN_AND) ||
                   (fn == FN_OR)  || (fn == FN_SLT);
  assign is_addi = (opc == OP_ADDI);
  assign is_lw   = (opc == OP_LW);
  assign is_sw   = (opc == OP_SW);
  assign is_beq  = (opc == OP_BEQ);
  assign is_bne  = (opc == OP_BNE);
  assign is_j    = (opc == OP_J);
  assign is_halt = (opc == OP_HALT);
  assign illegal = !((is_r && r_ok) || is_addi || is_lw || is_sw ||
                     is_beq || is_bne || is_j || is_halt);

  function automatic logic [31:0] alu_calc(input logic        r_type,
                                           input logic [5:0]  f,
                                           input logic [31:0] x,
                                           input logic [31:0] y);
    logic signed [31:0] xs;
    logic signed [31:0] ys;
    xs = x;
    ys = y;
    if (!r_type) return x + y;
    case (f)
      FN_SUB:  return x - y;
      FN_AND:  return x & y;
      FN_OR:   return x | y;
      FN_SLT:  return {31'd0, (xs < ys)};
      default: return x + y;
    endcase
  endfunction

  logic [31:0] pc_ext, pc_plus4, br_tgt, j_tgt, pc_nx, alu_b;
  logic        br_taken;

  assign pc_ext   = 32'(pc_q);
  assign pc_plus4 = pc_ext + 32'd4;
  assign br_tgt   = pc_plus4 + {imm_sx[29:0], 2'b00};
  assign j_tgt    = {pc_plus4[31:28], ir_q[25:0], 2'b00};
  assign alu_b    = is_r ? b_q : imm_sx;
  assign br_taken = (is_beq && (a_q == b_q)) || (is_bne && (a_q != b_q));

  always_comb begin
    pc_nx = pc_plus4;
    if (state_q == S_DECODE && is_j)
      pc_nx = j_tgt;
    else if (state_q == S_EXEC && br_taken)
      pc_nx = tgt_q;
  end

  // Undefined instructions reach WB too but never write the register file.
  logic [4:0]  wb_dst;
  logic        wb_kind, wb_en;
  logic [31:0] wb_data;

  assign wb_dst  = is_r ? rd : rt;
  assign wb_kind = (is_r && r_ok) || is_addi || is_lw;
  assign wb_en   = (state_q == S_WB) && wb_kind && (wb_dst != 5'd0);
  assign wb_data = is_lw ? mdr_q : alu_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        if (is_halt)
          state_d = S_HALT;
`ifdef MIPS_MC_ILLEGAL_TRAP_EN
        else if (illegal)
          state_d = S_HALT;
`endif
        else if (is_j)
          state_d = S_FETCH;
        else
          state_d = S_EXEC;
      end
      S_EXEC: begin
        if (is_beq || is_bne)     state_d = S_FETCH;
        else if (is_lw || is_sw)  state_d = S_MEM;
        else                      state_d = S_WB;
      end
      S_MEM:    if (mem_ready) state_d = is_sw ? S_FETCH : S_WB;
      S_WB:     state_d = S_FETCH;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_FETCH;
    endcase
  end

  // Request drops combinationally with rst so an in-flight access is abandoned at once.
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = pc_q;
    mem_wdata = 32'd0;
    retire    = 1'b0;
    halted    = 1'b0;
    case (state_q)
      S_FETCH:  mem_req = 1'b1;
      S_DECODE: retire  = is_j;
      S_EXEC:   retire  = is_beq || is_bne;
      S_MEM: begin
        mem_req   = 1'b1;
        mem_addr  = {alu_q[ADDR_W-1:2], 2'b00};
        mem_we    = is_sw;
        mem_wdata = is_sw ? b_q : 32'd0;
        retire    = is_sw && mem_ready;
      end
      S_WB:     retire = 1'b1;
      S_HALT:   halted = 1'b1;
      default:  ;
    endcase
    if (rst) mem_req = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= RESET_PC[ADDR_W-1:0];
      ir_q <= 32'd0;
    end else begin
      if (state_q == S_FETCH && mem_ready) ir_q <= mem_rdata;
      if (retire)                          pc_q <= pc_nx[ADDR_W-1:0];
    end
  end

  // Operand/result latches between phases; always written before they are consumed.
  always_ff @(posedge clk) begin
    if (state_q == S_DECODE) begin
      a_q   <= rf[rs];
      b_q   <= rf[rt];
      tgt_q <= br_tgt;
    end
    if (state_q == S_EXEC)               alu_q <= alu_calc(is_r, fn, a_q, alu_b);
    if (state_q == S_MEM && mem_ready)   mdr_q <= mem_rdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) rf[i] <= 32'd0;
    end else if (wb_en) begin
      rf[wb_dst] <= wb_data;
    end
  end

  assign pc = pc_q;

  logic unused_bits;
  assign unused_bits = ^{ir_q[10:6], alu_q[1:0], illegal};

endmodule

// File: tb/tb_mips_multicycle_core.sv
// Scoreboard bench for mips_multicycle_core: expected retires and stores are queued as programs are loaded.
module tb_mips_multicycle_core;

`ifdef MIPS_MC_ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        mem_req, mem_we, mem_ready, retire, halted;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, pc;

  mips_multicycle_core #(.RESET_PC(32'h0), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .pc(pc), .retire(retire), .halted(halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [31:0] pc; int cyc; } ret_t;
  typedef struct { logic [31:0] a; logic [31:0] d; } st_t;
  ret_t ret_q[$];
  st_t  st_q[$];

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Memory model: program image plus a store overlay that is cleared on reset.
  logic [31:0] mem    [256];
  logic [31:0] st_mem [256];
  logic [255:0] st_vld;
  int          mem_waits;
  int          wcnt;
  logic [7:0]  idx;

  always_comb begin
    idx       = mem_addr[9:2];
    mem_ready = mem_req && (wcnt >= mem_waits);
    mem_rdata = st_vld[idx] ? st_mem[idx] : mem[idx];
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      wcnt   <= 0;
      st_vld <= '0;
    end else if (mem_req && mem_ready) begin
      wcnt <= 0;
      if (mem_we) begin
        st_mem[idx] <= mem_wdata;
        st_vld[idx] <= 1'b1;
      end
    end else if (mem_req) begin
      wcnt <= wcnt + 1;
    end
  end

  // Output monitor, sampled on the falling edge.
  int          ic;
  bit          in_wait;
  logic [31:0] hold_addr, hold_wd;

  always @(negedge clk) begin
    if (rst) begin
      ic      = 0;
      in_wait = 1'b0;
    end else begin
      ic++;
      if (mem_req && !mem_ready) begin
        if (!in_wait) begin
          hold_addr = mem_addr;
          hold_wd   = mem_wdata;
          in_wait   = 1'b1;
        end else begin
          check("addr_stable", mem_addr, hold_addr);
          check("wdata_stable", mem_wdata, hold_wd);
        end
      end else if (mem_req && mem_ready) begin
        if (in_wait) check("addr_stable_acc", mem_addr, hold_addr);
        in_wait = 1'b0;
        check("addr_align", {30'd0, mem_addr[1:0]}, 32'd0);
        if (mem_we) begin
          if (st_q.size() == 0) begin
            check("store_extra", {31'd0, mem_we}, 32'd0);
          end else begin
            st_t s;
            s = st_q.pop_front();
            check("store_addr", mem_addr, s.a);
            check("store_data", mem_wdata, s.d);
          end
        end
      end else begin
        in_wait = 1'b0;
      end
      if (retire) begin
        if (ret_q.size() == 0) begin
          check("retire_extra", {31'd0, retire}, 32'd0);
        end else begin
          ret_t e;
          e = ret_q.pop_front();
          check("retire_pc", pc, e.pc);
          check("retire_cycles", ic, e.cyc);
        end
        ic = 0;
      end
    end
  end

  // Program construction helpers
  logic [31:0] ld_pc;
  logic [31:0] halt_pc;

  function automatic logic [31:0] enc_r(input int s, input int t, input int d, input logic [5:0] f);
    return {6'h00, 5'(s), 5'(t), 5'(d), 5'd0, f};
  endfunction
  function automatic logic [31:0] enc_i(input logic [5:0] op, input int s, input int t, input logic [15:0] imm);
    return {op, 5'(s), 5'(t), imm};
  endfunction
  function automatic logic [31:0] enc_j(input logic [25:0] tgt);
    return {6'h02, tgt};
  endfunction

  task automatic clear_prog();
    for (int i = 0; i < 256; i++) mem[i] = 32'd0;
    ret_q.delete();
    st_q.delete();
    ld_pc = 32'd0;
  endtask
  task automatic place(input logic [31:0] ins);
    mem[ld_pc[9:2]] = ins;
    ld_pc = ld_pc + 32'd4;
  endtask
  task automatic emit(input logic [31:0] ins, input int cyc);
    ret_t e;
    e.pc  = ld_pc;
    e.cyc = cyc;
    ret_q.push_back(e);
    place(ins);
  endtask
  task automatic exp_st(input logic [31:0] a, input logic [31:0] d);
    st_t s;
    s.a = a;
    s.d = d;
    st_q.push_back(s);
  endtask

  task automatic start(input int w);
    rst       = 1'b1;
    mem_waits = w;
    @(negedge clk);
    check("rst_req", {31'd0, mem_req}, 32'd0);
    check("rst_we", {31'd0, mem_we}, 32'd0);
    check("rst_addr", mem_addr, 32'd0);
    check("rst_wdata", mem_wdata, 32'd0);
    check("rst_pc", pc, 32'd0);
    check("rst_retire", {31'd0, retire}, 32'd0);
    check("rst_halted", {31'd0, halted}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("req_after_rst", {31'd0, mem_req}, 32'd1);
    check("fetch_addr0", mem_addr, 32'd0);
  endtask

  task automatic finish_prog(input int budget);
    int n;
    n = 0;
    while (!halted && n < budget) begin
      @(posedge clk);
      n++;
    end
    check("halt_reached", {31'd0, halted}, 32'd1);
    repeat (3) begin
      @(negedge clk);
      check("halt_flag", {31'd0, halted}, 32'd1);
      check("halt_req", {31'd0, mem_req}, 32'd0);
      check("halt_retire", {31'd0, retire}, 32'd0);
      check("halt_pc", pc, halt_pc);
    end
    check("retires_left", ret_q.size(), 32'd0);
    check("stores_left", st_q.size(), 32'd0);
  endtask

  initial begin
    rst       = 1'b1;
    mem_waits = 0;

    // Program 1: arithmetic, $0 protection, stores, branches, jump, loads, undefined instructions.
    clear_prog();
    emit(enc_i(6'h08, 0, 1, 16'h0005), 4);
    emit(enc_i(6'h08, 0, 2, 16'hFFFD), 4);
    emit(enc_r(1, 2, 3, 6'h20), 4);
    emit(enc_r(2, 1, 4, 6'h2A), 4);
    emit(enc_r(2, 1, 7, 6'h22), 4);
    emit(enc_r(1, 2, 8, 6'h24), 4);
    emit(enc_r(1, 2, 9, 6'h25), 4);
    emit(enc_r(1, 2, 10, 6'h2A), 4);
    emit(enc_r(1, 1, 0, 6'h20), 4);
    emit(enc_r(0, 0, 6, 6'h20), 4);
    emit(enc_i(6'h2B, 0, 3, 16'h0200), 4);  exp_st(32'h200, 32'd2);
    emit(enc_i(6'h2B, 0, 4, 16'h0204), 4);  exp_st(32'h204, 32'd1);
    emit(enc_i(6'h2B, 0, 7, 16'h0208), 4);  exp_st(32'h208, 32'hFFFF_FFF8);
    emit(enc_i(6'h2B, 0, 8, 16'h020C), 4);  exp_st(32'h20C, 32'd5);
    emit(enc_i(6'h2B, 0, 9, 16'h0210), 4);  exp_st(32'h210, 32'hFFFF_FFFD);
    emit(enc_i(6'h2B, 0, 10, 16'h0214), 4); exp_st(32'h214, 32'd0);
    emit(enc_i(6'h2B, 0, 6, 16'h0218), 4);  exp_st(32'h218, 32'd0);
    emit(enc_i(6'h04, 1, 1, 16'h0002), 3);  // 0x44 taken -> 0x50
    place(enc_i(6'h08, 0, 6, 16'h0063));
    place(enc_i(6'h08, 0, 6, 16'h0063));
    emit(enc_i(6'h05, 1, 1, 16'h0002), 3);  // 0x50 not taken -> 0x54
    emit(enc_i(6'h05, 1, 2, 16'h0001), 3);  // 0x54 taken -> 0x5C
    place(enc_i(6'h08, 0, 6, 16'h0063));
    emit(enc_i(6'h04, 1, 2, 16'h0001), 3);  // 0x5C not taken -> 0x60
    emit(enc_j(26'h40), 2);                 // 0x60 -> 0x100
    ld_pc = 32'h100;
    emit(enc_i(6'h23, 0, 5, 16'h0204), 5);
    emit(enc_i(6'h2B, 0, 5, 16'h021C), 4);  exp_st(32'h21C, 32'd1);
    emit(enc_i(6'h08, 0, 12, 16'hFFFF), 4);
    emit(enc_i(6'h2B, 0, 12, 16'h0220), 4); exp_st(32'h220, 32'hFFFF_FFFF);
    emit(enc_i(6'h23, 0, 15, 16'h0223), 5);
    emit(enc_i(6'h2B, 0, 15, 16'h0224), 4); exp_st(32'h224, 32'hFFFF_FFFF);
    if (TRAP) begin
      halt_pc = ld_pc;
      place({6'h3E, 26'd0});
      place(enc_r(1, 1, 16, 6'h21));
      place(enc_i(6'h2B, 0, 16, 16'h0228));
      place({6'h3F, 26'd0});
    end else begin
      emit({6'h3E, 26'd0}, 4);
      emit(enc_r(1, 1, 16, 6'h21), 4);
      emit(enc_i(6'h2B, 0, 16, 16'h0228), 4); exp_st(32'h228, 32'd0);
      halt_pc = ld_pc;
      place({6'h3F, 26'd0});
    end
    start(0);
    finish_prog(3000);

    // Program 2: two wait states on every memory request.
    clear_prog();
    emit(enc_j(26'h40), 4);
    ld_pc = 32'h100;
    emit(enc_i(6'h08, 0, 1, 16'h0005), 6);
    emit(enc_i(6'h2B, 0, 1, 16'h0008), 8);  exp_st(32'h8, 32'd5);
    emit(enc_i(6'h23, 0, 5, 16'h0008), 9);
    emit(enc_i(6'h2B, 0, 5, 16'h000C), 8);  exp_st(32'hC, 32'd5);
    halt_pc = ld_pc;
    place({6'h3F, 26'd0});
    start(2);
    finish_prog(3000);

    // Program 3: reset while a store waits, then verify registers came back as zero.
    clear_prog();
    emit(enc_i(6'h08, 0, 1, 16'h0007), 9);
    place(enc_i(6'h2B, 0, 1, 16'h0040));
    start(5);
    begin
      int n;
      n = 0;
      while (!(mem_req && mem_we) && n < 200) begin
        @(negedge clk);
        n++;
      end
      check("sw_started", {31'd0, mem_we}, 32'd1);
      check("sw_addr", mem_addr, 32'h40);
      repeat (2) @(negedge clk);
      #2 rst = 1'b1;
      #1 check("rst_req_drop", {31'd0, mem_req}, 32'd0);
      check("pc_after_rst", pc, 32'd0);
      check("retires_before_rst", ret_q.size(), 32'd0);
    end
    clear_prog();
    emit(enc_i(6'h2B, 0, 1, 16'h0044), 4);  exp_st(32'h44, 32'd0);
    emit(enc_i(6'h2B, 0, 31, 16'h0048), 4); exp_st(32'h48, 32'd0);
    emit(enc_r(1, 1, 2, 6'h20), 4);
    emit(enc_i(6'h2B, 0, 2, 16'h004C), 4);  exp_st(32'h4C, 32'd0);
    halt_pc = ld_pc;
    place({6'h3F, 26'd0});
    start(0);
    finish_prog(3000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
